array_seq_ctrl: RTL and testbench
=================================

Name: array_seq_ctrl

Overview:
- Edge sequencer that drives the west and north edges of the 16x16 binary-parallel systolic array.
- Drives the west edge (en_i/clr_i/ifm per row) and the north edge (en_w/clr_w/wght per column), and collects the array's top-edge ofm outputs per column.
- Converts aligned upstream vectors into the row/column-skewed streams the array needs, and re-aligns the skewed column results into one output vector per input vector.
- Sits between the on-chip ifm/weight buffers and the array.

Parameters:
- HEIGHT, 16, array rows (ifm lanes)
- WIDTH, 16, array columns (weight/ofm lanes)
- IWIDTH, 8, signed ifm/weight element width
- OWIDTH, 24, signed ofm element width
- OLAT, 16, cycles from a row-0 ifm element entering column w to its result being valid on ofm[w]
- LENW, 16, counter width for cfg_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- cfg_len  in  LENW  number of ifm vectors per pass; 0 is treated as 1
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse at end of pass
- wght_valid  in  1  upstream weight row valid
- wght_ready  out  1  weight row accepted when valid&&ready
- wght_in  in  WIDTH x IWIDTH  one weight row, element w for column w
- ifm_valid  in  1  upstream ifm vector valid
- ifm_ready  out  1  ifm vector accepted when valid&&ready
- ifm_in  in  HEIGHT x IWIDTH  one ifm vector, element h for row h
- en_i, clr_i, en_w, clr_w, en_o, clr_o  out  HEIGHT or WIDTH  array edge controls
- ifm  out  HEIGHT x IWIDTH  to array
- wght  out  WIDTH x IWIDTH  to array
- ofm  in  WIDTH x OWIDTH  from array top edge
- ofm_valid  out  1  aligned result vector valid; no backpressure
- ofm_out  out  WIDTH x OWIDTH  aligned result vector

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, counters 0, all skew registers 0. busy, done, wght_ready, ifm_ready, ofm_valid = 0. All en_*/clr_* = 0; ifm, wght, ofm_out = 0.
- FSM: IDLE -> CLR -> LOADW -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE: start=1 latches cfg_len (0->1) and goes to CLR. start in any other state is ignored.
- CLR: 1 cycle. Pulses clr_i/clr_w/clr_o unskewed source; it reaches lane k k cycles later through the skew chain.
- LOADW:
  - wght_ready=1.
  - Each accepted row r (HEIGHT rows, r=0 first) is launched into the column skew line: column w sees en_w=1 and wght=wght_in[w] exactly 1+w cycles after acceptance.
  - Upstream stall inserts bubbles: en_w=0, wght=0.
  - After HEIGHT rows, waits WIDTH cycles (skew drain), then enters STREAM.
- STREAM:
  - ifm_ready=1.
  - Vector k accepted at cycle t drives row h with en_i=1, ifm=ifm_in[h] at t+1+h.
  - Stall cycles give en_i=0, ifm=0 on the skewed lanes.
  - After cfg_len accepts, enters FLUSH.
- en_o[w]: high whenever the state is STREAM or FLUSH, delayed by w cycles.
- FLUSH: counts HEIGHT+WIDTH+OLAT cycles, then enters DONE.
- DONE: done=1 for one cycle, busy drops the next cycle.
- Output capture:
  - A valid token per accepted ifm vector travels a shift line.
  - ofm[w] is captured at t+1+w+OLAT.
  - Captured values are held in per-column deskew registers.
  - ofm_valid=1 with all WIDTH columns at t+WIDTH+OLAT+1. Exactly one ofm_valid per accepted ifm vector, in order, with bubbles preserved.
- Simultaneous valid and stall: only valid&&ready transfers. ready is a pure function of state (no combinational path from valid).
- Reset mid-pass: everything returns to reset values next cycle. No done, no further ofm_valid.
- Arithmetic: none on data. Counters saturate nowhere; widths are sized to their limits.

Optional Feature:
- Macro: ARRAY_SEQ_PERF_EN.
- Defined: adds outputs perf_cycles (32b, cycles busy=1) and perf_stalls (32b, LOADW/STREAM cycles with valid=0). Both clear on start and hold after done.
- Undefined: the ports and logic are absent.

Decomposition:
- Package array_seq_pkg holds the state enum typedef (IDLE, CLR, LOADW, STREAM, FLUSH, DONE) and shared localparams (skew depth, flush length).
- One natural sub-module, skew_line: parameterised lane count, per-lane delay 1+lane, carrying {en, clr, data}. Instantiated twice (rows, columns).
- Output deskew uses the same structure in reverse (delay WIDTH-1-w).

Test Plan:
- Reset then idle: rst=1 for 3 cycles, start=0 -> all outputs 0, busy=0, no ofm_valid for 50 cycles.
- Weight skew: continuous valid, wght_in[w]=w+1 per row. Column 5 must show en_w=1 with value 6 exactly 6 cycles after row 0 accept, for 16 consecutive cycles.
- IFM skew with stalls: cfg_len=4, ifm_valid toggled 1,0,1,1,0,1. Row 15 shows en_i pattern 1,0,1,1,0,1 delayed 16 cycles, with ifm=0 in bubbles.
- Output alignment: array model returns ofm[w]=k*100+w at the sampling cycle for vector k, cfg_len=3. Expect 3 ofm_valid pulses; vector 1 gives ofm_out[w]=100+w for all w, arriving 16+16+1 cycles after its accept.
- cfg_len=0 and start while busy: exactly 1 vector is consumed; a second start during STREAM is ignored; done pulses once.
- Mid-pass reset: rst=1 during STREAM at vector 2 of 8 -> next cycle busy=0, all en_*=0, no done, no later ofm_valid.

Source files
------------

// File: rtl/array_seq_pkg.sv
// Shared state type and sequencing constants for the systolic-array edge sequencer.
// Optional perf counters in array_seq_ctrl are enabled by defining ARRAY_SEQ_PERF_EN.
package array_seq_pkg;

  typedef enum logic [2:0] {IDLE, CLR, LOADW, STREAM, FLUSH, DONE} state_t;

  localparam int SKEW_BASE = 1;  // lane k of a forward skew line lags its source by SKEW_BASE+k

  // Cycles after the last ifm accept until every result has left the array.
  function automatic int flush_len(input int h, input int w, input int olat);
    return h + w + olat;
  endfunction

endpackage

// File: rtl/array_seq_ctrl_skew_line.sv
// Per-lane delay line. Forward: lane k delays 1+k cycles; REV: lane k delays LANES-1-k.
// Each lane carries an opaque packed word (callers pack {en, clr, data}).
module skew_line
  import array_seq_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 10,
  parameter bit REV   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0][DW-1:0]   din,
  output logic [LANES-1:0][DW-1:0]   dout
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int D = REV ? (LANES - 1 - k) : (SKEW_BASE + k);
    if (D == 0) begin : g_thru
      assign dout[k] = din[k];
    end else begin : g_dly
      logic [D-1:0][DW-1:0] sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          sr <= '0;
        end else begin
          sr[0] <= din[k];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign dout[k] = sr[D-1];
    end
  end

endmodule

// File: rtl/array_seq_ctrl.sv
// Edge sequencer for the HEIGHTxWIDTH systolic array: skews weights/ifm in, deskews ofm out.
// Define ARRAY_SEQ_PERF_EN to add perf_cycles / perf_stalls counters.
module array_seq_ctrl
  import array_seq_pkg::*;
#(
  parameter int HEIGHT = 16,
  parameter int WIDTH  = 16,
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int OLAT   = 16,
  parameter int LENW   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LENW-1:0]                cfg_len,
  output logic                           busy,
  output logic                           done,
  input  logic                           wght_valid,
  output logic                           wght_ready,
  input  logic [WIDTH-1:0][IWIDTH-1:0]   wght_in,
  input  logic                           ifm_valid,
  output logic                           ifm_ready,
  input  logic [HEIGHT-1:0][IWIDTH-1:0]  ifm_in,
  output logic [HEIGHT-1:0]              en_i,
  output logic [HEIGHT-1:0]              clr_i,
  output logic [WIDTH-1:0]               en_w,
  output logic [WIDTH-1:0]               clr_w,
  output logic [WIDTH-1:0]               en_o,
  output logic [WIDTH-1:0]               clr_o,
  output logic [HEIGHT-1:0][IWIDTH-1:0]  ifm,
  output logic [WIDTH-1:0][IWIDTH-1:0]   wght,
  input  logic [WIDTH-1:0][OWIDTH-1:0]   ofm,
`ifdef ARRAY_SEQ_PERF_EN
  output logic [31:0]                    perf_cycles,
  output logic [31:0]                    perf_stalls,
`endif
  output logic                           ofm_valid,
  output logic [WIDTH-1:0][OWIDTH-1:0]   ofm_out
);

  localparam int FLUSH_N = flush_len(HEIGHT, WIDTH, OLAT);
  localparam int FCW     = $clog2(FLUSH_N + 1);
  localparam int CW      = (LENW > FCW) ? LENW : FCW;
  localparam int STAGES  = WIDTH + OLAT - 1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [LENW-1:0] len, len_n;
  logic            drain, drain_n;
  logic            w_acc, i_acc, clr_src;

  // drain marks the post-load wait while the last weight row walks across the columns
  assign wght_ready = (state == LOADW) && !drain;
  assign ifm_ready  = (state == STREAM);
  assign w_acc      = wght_valid && wght_ready;
  assign i_acc      = ifm_valid && ifm_ready;
  assign clr_src    = (state == CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
      drain <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len   <= len_n;
      drain <= drain_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    drain_n = drain;
    busy    = (state != IDLE);
    done    = 1'b0;
    case (state)
      IDLE: if (start) begin
        len_n   = (cfg_len == '0) ? LENW'(1) : cfg_len;
        cnt_n   = '0;
        drain_n = 1'b0;
        state_n = CLR;
      end
      CLR: state_n = LOADW;
      LOADW: begin
        if (!drain) begin
          if (w_acc) begin
            if (cnt == CW'(HEIGHT - 1)) begin
              cnt_n   = '0;
              drain_n = 1'b1;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end else if (cnt == CW'(WIDTH - 1)) begin
          cnt_n   = '0;
          drain_n = 1'b0;
          state_n = STREAM;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STREAM: if (i_acc) begin
        if (cnt == CW'(len) - CW'(1)) begin
          cnt_n   = '0;
          state_n = FLUSH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt == CW'(FLUSH_N - 1)) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // West and north edges: bubbles carry zero data so the array sees clean operands.
  logic [HEIGHT-1:0][IWIDTH+1:0] row_d, row_q;
  logic [WIDTH-1:0][IWIDTH+1:0]  col_d, col_q;

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    assign row_d[h] = {i_acc, clr_src, i_acc ? ifm_in[h] : {IWIDTH{1'b0}}};
    assign {en_i[h], clr_i[h], ifm[h]} = row_q[h];
  end
  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    assign col_d[w] = {w_acc, clr_src, w_acc ? wght_in[w] : {IWIDTH{1'b0}}};
    assign {en_w[w], clr_w[w], wght[w]} = col_q[w];
  end

  skew_line #(.LANES(HEIGHT), .DW(IWIDTH + 2), .REV(1'b0)) u_row_skew (
    .clk(clk), .rst(rst), .din(row_d), .dout(row_q)
  );
  skew_line #(.LANES(WIDTH), .DW(IWIDTH + 2), .REV(1'b0)) u_col_skew (
    .clk(clk), .rst(rst), .din(col_d), .dout(col_q)
  );

  // Output-enable/clear wavefront: column w follows the state w cycles late.
  logic [1:0]            o_src;
  logic [WIDTH-2:0][1:0] o_sr;
  assign o_src = {clr_src, (state == STREAM) || (state == FLUSH)};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sr <= '0;
    end else begin
      o_sr[0] <= o_src;
      for (int i = 1; i < WIDTH - 1; i++) o_sr[i] <= o_sr[i-1];
    end
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_eo
    if (w == 0) begin : g_src
      assign {clr_o[w], en_o[w]} = o_src;
    end else begin : g_dly
      assign {clr_o[w], en_o[w]} = o_sr[w-1];
    end
  end

  // One token per accepted ifm vector; column w samples ofm when its token is 1+w+OLAT old.
  logic [STAGES:0]              vld_pipe;
  logic [WIDTH-1:0][OWIDTH:0]   cap, desk;
  logic [WIDTH-1:0]             desk_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      cap      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], i_acc};
      for (int w = 0; w < WIDTH; w++) begin
        cap[w][OWIDTH] <= vld_pipe[w + OLAT];
        if (vld_pipe[w + OLAT]) cap[w][OWIDTH-1:0] <= ofm[w];
      end
    end
  end

  skew_line #(.LANES(WIDTH), .DW(OWIDTH + 1), .REV(1'b1)) u_deskew (
    .clk(clk), .rst(rst), .din(cap), .dout(desk)
  );

  for (genvar w = 0; w < WIDTH; w++) begin : g_out
    assign desk_vld[w] = desk[w][OWIDTH];
    assign ofm_out[w]  = ofm_valid ? desk[w][OWIDTH-1:0] : {OWIDTH{1'b0}};
  end
  assign ofm_valid = &desk_vld;

`ifdef ARRAY_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((state == LOADW && !wght_valid) || (state == STREAM && !ifm_valid))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Scoreboard bench for array_seq_ctrl: stimulus pushes expected results, a negedge monitor checks.
module tb_array_seq_ctrl;

  localparam int H = 16, W = 16, IW = 8, OW = 24, OL = 16, LW = 16;
  localparam int HIST = 8192;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [LW-1:0]         cfg_len = '0;
  logic                  busy, done;
  logic                  wght_valid = 1'b0, wght_ready;
  logic [W-1:0][IW-1:0]  wght_in = '0;
  logic                  ifm_valid = 1'b0, ifm_ready;
  logic [H-1:0][IW-1:0]  ifm_in = '0;
  logic [H-1:0]          en_i, clr_i;
  logic [W-1:0]          en_w, clr_w, en_o, clr_o;
  logic [H-1:0][IW-1:0]  ifm;
  logic [W-1:0][IW-1:0]  wght;
  logic [W-1:0][OW-1:0]  ofm = '0;
  logic                  ofm_valid;
  logic [W-1:0][OW-1:0]  ofm_out;
`ifdef ARRAY_SEQ_PERF_EN
  logic [31:0]           perf_cycles, perf_stalls;
`endif

  array_seq_ctrl #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .OWIDTH(OW), .OLAT(OL), .LENW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .wght_valid(wght_valid), .wght_ready(wght_ready), .wght_in(wght_in),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_in(ifm_in),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .ifm(ifm), .wght(wght), .ofm(ofm),
`ifdef ARRAY_SEQ_PERF_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .ofm_valid(ofm_valid), .ofm_out(ofm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  int done_cnt = 0, acc_cnt = 0, kcnt = 0, ofm_seen = 0, sent = 0;
  int sb_k[$], sb_t[$];
  bit         we_h[HIST];
  logic [7:0] wd_h[HIST];
  bit         ie_h[HIST];
  logic [7:0] id_h[HIST];
  int         acc_k[HIST];
  int         mc, mk, mt, tc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Monitor + array model. The model returns k*100+w on ofm[w] exactly when vector k is
  // due at column w (1+w+OL cycles after its accept); anything else is junk.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST; i++) begin
        we_h[i] = 1'b0; wd_h[i] = '0; ie_h[i] = 1'b0; id_h[i] = '0; acc_k[i] = -1;
      end
      sb_k.delete(); sb_t.delete();
      ofm = {W{24'h5A5A5A}};
    end else begin
      if (start && !busy) begin kcnt = 0; acc_cnt = 0; end
      if (wght_valid && wght_ready) begin we_h[cyc] = 1'b1; wd_h[cyc] = wght_in[5]; end
      if (ifm_valid && ifm_ready) begin
        ie_h[cyc] = 1'b1; id_h[cyc] = ifm_in[15]; acc_k[cyc] = kcnt;
        sb_k.push_back(kcnt); sb_t.push_back(cyc);
        kcnt++; acc_cnt++;
      end
      if (done) done_cnt++;
      // column 5 lags its accept by 6 cycles, row 15 by 16
      mc = cyc - 6;
      chk("en_w5", {31'b0, en_w[5]}, (mc >= 0) ? {31'b0, we_h[mc]} : 32'd0);
      chk("wght5", {24'b0, wght[5]}, (mc >= 0) ? {24'b0, wd_h[mc]} : 32'd0);
      mc = cyc - 16;
      chk("en_i15", {31'b0, en_i[15]}, (mc >= 0) ? {31'b0, ie_h[mc]} : 32'd0);
      chk("ifm15", {24'b0, ifm[15]}, (mc >= 0) ? {24'b0, id_h[mc]} : 32'd0);
      if (ofm_valid) begin
        ofm_seen++;
        if (sb_k.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL ofm_unexpected @cyc %0d: got ofm_valid=1 want no result pending", cyc);
        end else begin
          mk = sb_k.pop_front(); mt = sb_t.pop_front();
          chk("ofm_latency", cyc - mt, W + OL + 1);
          for (int w = 0; w < W; w++) chk("ofm_out", {8'b0, ofm_out[w]}, mk * 100 + w);
        end
      end
      for (int w = 0; w < W; w++) begin
        tc = cyc - 1 - w - OL;
        ofm[w] = (tc >= 0 && acc_k[tc] >= 0) ? OW'(acc_k[tc] * 100 + w) : 24'h5A5A5A;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1; cfg_len = LW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stream();
    for (int i = 0; i < 200 && !ifm_ready; i++) tick();
    chk("reach_stream", {31'b0, ifm_ready}, 32'd1);
  endtask

  task automatic set_ifm();
    for (int h = 0; h < H; h++) ifm_in[h] = IW'(sent * 16 + h + 1);
  endtask

  task automatic drive_pattern(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      ifm_valid = pat[i];
      set_ifm();
      if (pat[i]) sent++;
      tick();
    end
    ifm_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) tick();
    chk("done_count", done_cnt, target);
    tick(); tick();
    chk("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    // reset values (still in reset)
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("rst_ready", {30'b0, wght_ready, ifm_ready}, 32'd0);
    chk("rst_en", {en_i, en_w}, 32'd0);
    chk("rst_en_o_clr", {clr_i, en_o}, 32'd0);
    chk("rst_ofm_valid", {31'b0, ofm_valid}, 32'd0);
    chk("rst_data", {31'b0, (ifm != '0) || (wght != '0) || (ofm_out != '0)}, 32'd0);
    rst = 1'b0;
    repeat (50) tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_no_ofm", ofm_seen, 0);

    // pass A: continuous weights w+1, ifm with bubbles 1,0,1,1,0,1
    for (int w = 0; w < W; w++) wght_in[w] = IW'(w + 1);
    wght_valid = 1'b1;
    sent = 0;
    pulse_start(4);
    wait_stream();
    drive_pattern(16'b10_1101, 6);
    wait_done(1);
    chk("A_accepts", acc_cnt, 4);
    chk("A_results", ofm_seen, 4);

    // pass B: 3 back-to-back vectors
    sent = 0;
    pulse_start(3);
    wait_stream();
    drive_pattern(16'b111, 3);
    wait_done(2);
    chk("B_accepts", acc_cnt, 3);
    chk("B_results", ofm_seen, 7);

    // pass C: cfg_len=0 consumes one vector; start during STREAM ignored
    sent = 0;
    pulse_start(0);
    wait_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    ifm_valid = 1'b1; set_ifm();
    repeat (6) tick();
    ifm_valid = 1'b0;
    wait_done(3);
    chk("C_accepts", acc_cnt, 1);
    repeat (20) tick();
    chk("C_single_done", done_cnt, 3);
    chk("C_idle", {31'b0, busy}, 32'd0);
    chk("C_results", ofm_seen, 8);

    // pass D: reset while vector 2 of 8 is presented
    sent = 0;
    pulse_start(8);
    wait_stream();
    ifm_valid = 1'b1;
    for (int i = 0; i < 50 && acc_cnt < 2; i++) begin
      set_ifm(); sent = acc_cnt; set_ifm();
      tick();
    end
    set_ifm();
    chk("D_two_accepted", acc_cnt, 2);
    seen0 = ofm_seen;
    rst = 1'b1;
    tick();
    chk("D_rst_busy", {31'b0, busy}, 32'd0);
    chk("D_rst_en", {en_i, en_w}, 32'd0);
    chk("D_rst_en_o", {16'b0, en_o}, 32'd0);
    rst = 1'b0;
    ifm_valid = 1'b0;
    repeat (100) tick();
    chk("D_no_done", done_cnt, 3);
    chk("D_no_ofm", ofm_seen, seen0);
    chk("sb_drained", sb_k.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
